// File: rtl/alu_issue_queue_if.sv
// Bundle of the request, ALU, response and status signals of the ALU issue queue.
// The slave view belongs to the queue. The master view belongs to its environment (requester, ALU, consumer).
interface alu_issue_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [15:0]   req_a;
  logic [15:0]   req_b;
  logic [3:0]    req_tag;
  logic [3:0]    alu_op;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [15:0]   alu_c;
  logic          alu_ofl;
  logic          alu_err;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_c;
  logic          rsp_ofl;
  logic          rsp_err;
  logic [3:0]    rsp_tag;
  logic          clr_sticky;
  logic          sticky_ofl;
  logic          sticky_err;
  logic [CW-1:0] count;
  logic          busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag,
    output req_ready,
    output alu_op, alu_a, alu_b,
    input  alu_c, alu_ofl, alu_err,
    output rsp_valid, rsp_c, rsp_ofl, rsp_err, rsp_tag,
    input  rsp_ready,
    input  clr_sticky,
    output sticky_ofl, sticky_err, count, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag,
    input  req_ready,
    input  alu_op, alu_a, alu_b,
    output alu_c, alu_ofl, alu_err,
    input  rsp_valid, rsp_c, rsp_ofl, rsp_err, rsp_tag,
    output rsp_ready,
    output clr_sticky,
    input  sticky_ofl, sticky_err, count, busy
  );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU issue queue: one-entry issue register that feeds a combinational ALU, plus a
// result FIFO that carries tags and sticky overflow/error status.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  alu_issue_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 22;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic          iss_valid_r;
  logic [3:0]    iss_op_r;
  logic [15:0]   iss_a_r;
  logic [15:0]   iss_b_r;
  logic [3:0]    iss_tag_r;
  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          sticky_ofl_r;
  logic          sticky_err_r;

  logic          rsp_valid_s;
  logic          pop_s;
  logic          can_write_s;
  logic          req_ready_s;
  logic          accept_s;

  // Handshake qualifiers; a pop frees a slot that the issue register can refill on the same edge.
  always_comb begin
    rsp_valid_s = (count_r != CNT_ZERO);
    pop_s       = rsp_valid_s && bus.rsp_ready;
    can_write_s = iss_valid_r && ((count_r < CNT_FULL) || pop_s);
    req_ready_s = !iss_valid_r || can_write_s;
    accept_s    = bus.req_valid && req_ready_s;
  end

  // Issue register: loaded on accept, emptied when its result enters the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_r <= 1'b0;
      iss_op_r    <= 4'h0;
      iss_a_r     <= 16'h0000;
      iss_b_r     <= 16'h0000;
      iss_tag_r   <= 4'h0;
    end else if (accept_s) begin
      iss_valid_r <= 1'b1;
      iss_op_r    <= bus.req_op;
      iss_a_r     <= bus.req_a;
      iss_b_r     <= bus.req_b;
      iss_tag_r   <= bus.req_tag;
    end else if (can_write_s) begin
      iss_valid_r <= 1'b0;
    end
  end

  // Result FIFO storage and pointers; entries are cleared so an empty head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (can_write_s) begin
        mem_r[wr_ptr_r] <= {iss_tag_r, bus.alu_err, bus.alu_ofl, bus.alu_c};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy counter; a write and a pop on the same edge leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({can_write_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky status; a capture with the flag set wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ofl_r <= 1'b0;
      sticky_err_r <= 1'b0;
    end else begin
      if (can_write_s && bus.alu_ofl) begin
        sticky_ofl_r <= 1'b1;
      end else if (bus.clr_sticky) begin
        sticky_ofl_r <= 1'b0;
      end
      if (can_write_s && bus.alu_err) begin
        sticky_err_r <= 1'b1;
      end else if (bus.clr_sticky) begin
        sticky_err_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.alu_op     = iss_valid_r ? iss_op_r : 4'h0;
  assign bus.alu_a      = iss_valid_r ? iss_a_r  : 16'h0000;
  assign bus.alu_b      = iss_valid_r ? iss_b_r  : 16'h0000;
  assign bus.rsp_valid  = rsp_valid_s;
  assign {bus.rsp_tag, bus.rsp_err, bus.rsp_ofl, bus.rsp_c} = mem_r[rd_ptr_r];
  assign bus.sticky_ofl = sticky_ofl_r;
  assign bus.sticky_err = sticky_err_r;
  assign bus.count      = count_r;
  assign bus.busy       = iss_valid_r || rsp_valid_s;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed testbench for alu_issue_queue. It includes a small behavioural ALU:
// 0x1 add (carry sets ofl), 0x9 and, 0xC shift left, 0xF error, any other opcode xor.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  alu_issue_queue_if #(.DEPTH(DEPTH)) bus ();

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      4'h1:    alu_model = {1'b0, sum[16], sum[15:0]};
      4'h9:    alu_model = {2'b00, a & b};
      4'hC:    alu_model = {2'b00, a << b[3:0]};
      4'hF:    alu_model = {2'b10, 16'h0000};
      default: alu_model = {2'b00, a ^ b};
    endcase
  endfunction

  always_comb begin
    {bus.alu_err, bus.alu_ofl, bus.alu_c} = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic v, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] tag);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
  endtask

  function automatic logic [3:0] wrap_op(input int i);
    case (i % 4)
      0:       wrap_op = 4'h1;
      1:       wrap_op = 4'h9;
      2:       wrap_op = 4'hC;
      default: wrap_op = 4'hF;
    endcase
  endfunction

  function automatic logic [15:0] wrap_a(input int i);
    wrap_a = 16'hF234 + 16'(i) * 16'h0F01;
  endfunction

  initial begin
    int sent;
    int recv;
    int cycles;
    logic [17:0] exp_v;
    logic hs_req;
    logic hs_rsp;

    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.rsp_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    drive_req(1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0);
    step();
    step();
    // Reset state
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_c", 32'(bus.rsp_c), 32'd0);
    check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_sticky", 32'({bus.sticky_ofl, bus.sticky_err}), 32'd0);
    rst = 1'b0;

    // Basic: 1 + 2, response two edges later
    bus.rsp_ready = 1'b1;
    drive_req(1'b1, 4'h1, 16'h0001, 16'h0002, 4'h5);
    #1 check("basic_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    check("basic_alu_op", 32'(bus.alu_op), 32'h1);
    check("basic_alu_b", 32'(bus.alu_b), 32'h2);
    check("basic_early_valid", 32'(bus.rsp_valid), 32'd0);
    check("basic_busy", 32'(bus.busy), 32'd1);
    step();
    check("basic_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("basic_rsp_c", 32'(bus.rsp_c), 32'h0003);
    check("basic_rsp_ofl", 32'(bus.rsp_ofl), 32'd0);
    check("basic_rsp_tag", 32'(bus.rsp_tag), 32'h5);
    check("basic_sticky_ofl", 32'(bus.sticky_ofl), 32'd0);
    check("basic_alu_idle", 32'(bus.alu_a), 32'd0);
    step();
    check("basic_drained", 32'(bus.rsp_valid), 32'd0);
    check("basic_idle", 32'(bus.busy), 32'd0);

    // Overflow, sticky set/clear, set wins over clear
    drive_req(1'b1, 4'h1, 16'hFFFF, 16'h0001, 4'h6);
    step();
    bus.req_valid = 1'b0;
    step();
    check("ofl_rsp_c", 32'(bus.rsp_c), 32'h0000);
    check("ofl_rsp_ofl", 32'(bus.rsp_ofl), 32'd1);
    check("ofl_rsp_tag", 32'(bus.rsp_tag), 32'h6);
    check("ofl_sticky", 32'(bus.sticky_ofl), 32'd1);
    step();
    check("ofl_sticky_hold", 32'(bus.sticky_ofl), 32'd1);
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    check("ofl_sticky_clr", 32'(bus.sticky_ofl), 32'd0);
    drive_req(1'b1, 4'h1, 16'h8000, 16'h8000, 4'h7);
    step();
    bus.req_valid  = 1'b0;
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    check("ofl_set_wins", 32'(bus.sticky_ofl), 32'd1);
    check("ofl_tag7", 32'(bus.rsp_tag), 32'h7);
    step();
    check("ofl_count0", 32'(bus.count), 32'd0);

    // Back-to-back: 8 requests on 8 consecutive cycles, responses on 8 consecutive cycles
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        if (i % 2 == 0) drive_req(1'b1, 4'h9, 16'hF0F0, 16'h0FF0, 4'(i));
        else            drive_req(1'b1, 4'hC, 16'h0001, 16'h0004, 4'(i));
        #1 check("b2b_req_ready", 32'(bus.req_ready), 32'd1);
      end else begin
        bus.req_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        check("b2b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b_rsp_tag", 32'(bus.rsp_tag), 32'(i - 1));
        check("b2b_rsp_c", 32'(bus.rsp_c), ((i - 1) % 2 == 0) ? 32'h00F0 : 32'h0010);
      end
    end
    step();
    check("b2b_drained", 32'(bus.count), 32'd0);

    // Full: DEPTH+1 accepted, then backpressure until a pop
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b1, 4'h1, 16'(i), 16'h0001, 4'(i));
      #1 check("full_accept", 32'(bus.req_ready), 32'd1);
      step();
    end
    drive_req(1'b1, 4'h1, 16'h0005, 16'h0001, 4'h5);
    #1 check("full_req_ready", 32'(bus.req_ready), 32'd0);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_busy", 32'(bus.busy), 32'd1);
    check("full_head", 32'(bus.rsp_tag), 32'h0);
    step();
    check("full_stall", 32'(bus.req_ready), 32'd0);
    check("full_head_stable", 32'(bus.rsp_c), 32'h0001);
    bus.rsp_ready = 1'b1;
    #1 check("full_pop_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    #1 check("full_count_kept", 32'(bus.count), 32'd4);
    check("full_next_head", 32'(bus.rsp_tag), 32'h1);
    bus.rsp_ready = 1'b1;
    for (int t = 1; t < 6; t++) begin
      check("full_drain_valid", 32'(bus.rsp_valid), 32'd1);
      check("full_drain_tag", 32'(bus.rsp_tag), 32'(t));
      check("full_drain_c", 32'(bus.rsp_c), 32'(t + 1));
      step();
    end
    check("full_empty", 32'(bus.count), 32'd0);
    check("full_idle", 32'(bus.busy), 32'd0);

    // Wrap-around: 3*DEPTH requests with random consumer throttling
    sent   = 0;
    recv   = 0;
    cycles = 0;
    while (recv < 3 * DEPTH && cycles < 300) begin
      if (sent < 3 * DEPTH) drive_req(1'b1, wrap_op(sent), wrap_a(sent), 16'(sent), 4'(sent));
      else                  bus.req_valid = 1'b0;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      hs_req = bus.req_valid && bus.req_ready;
      hs_rsp = bus.rsp_valid && bus.rsp_ready;
      if (hs_rsp) begin
        exp_v = alu_model(wrap_op(recv), wrap_a(recv), 16'(recv));
        check("wrap_tag", 32'(bus.rsp_tag), 32'(recv));
        check("wrap_c", 32'(bus.rsp_c), 32'(exp_v[15:0]));
        check("wrap_flags", 32'({bus.rsp_err, bus.rsp_ofl}), 32'(exp_v[17:16]));
      end
      step();
      if (hs_req) sent++;
      if (hs_rsp) recv++;
      cycles++;
    end
    check("wrap_all_received", 32'(recv), 32'(3 * DEPTH));
    check("wrap_sticky_err", 32'(bus.sticky_err), 32'd1);

    // Asynchronous reset with three results queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 4'h1, 16'h0010, 16'(i), 4'(i));
      step();
    end
    bus.req_valid = 1'b0;
    check("arst_pre_count", 32'(bus.count), 32'd3);
    check("arst_pre_sticky", 32'(bus.sticky_ofl), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    check("arst_req_ready", 32'(bus.req_ready), 32'd1);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_sticky", 32'({bus.sticky_ofl, bus.sticky_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    drive_req(1'b1, 4'h1, 16'h0002, 16'h0003, 4'h9);
    step();
    bus.req_valid = 1'b0;
    step();
    check("arst_first_valid", 32'(bus.rsp_valid), 32'd1);
    check("arst_first_tag", 32'(bus.rsp_tag), 32'h9);
    check("arst_first_c", 32'(bus.rsp_c), 32'h0005);
    step();
    check("arst_no_stale", 32'(bus.rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
